// File: rtl/fifo_pop_reader.sv
// Drain stage between the FIFO and the next pipeline block: credit-based pop issue,
// 1-cycle read capture into a 3-entry buffer, valid/ready delivery and word counting.
module fifo_pop_reader #(
  parameter int data_width  = 10,
  parameter int count_width = 8
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   empty_fifo,
  input  logic                   almost_empty_fifo,
  input  logic [data_width-1:0]  FIFO_data_out,
  output logic                   pop,
  output logic [data_width-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [count_width-1:0] word_count,
  output logic [1:0]             state,
  output logic                   low_water
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [data_width-1:0]  buf_r [0:2];
  logic [1:0]             wr_ptr_r, rd_ptr_r, occ_r, occ_nxt_s;
  logic                   inflight_r;
  logic [count_width-1:0] word_count_r;
  logic                   low_water_r;
  logic [2:0]             used_s, used_nxt_s;
  logic                   pop_s, handshake_s, wr_s;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit covers buffered words plus the word already requested from the FIFO.
  assign used_s      = {1'b0, occ_r} + {2'b00, inflight_r};
  assign pop_s       = reset_L & enable & ~flush & ~empty_fifo & (used_s < 3'd3)
                       & ((state_r != ST_IDLE) | enable);
  assign handshake_s = (occ_r != 2'd0) & out_ready & ~flush;
  assign wr_s        = inflight_r & ~flush;
  assign used_nxt_s  = {1'b0, occ_nxt_s} + {2'b00, pop_s};

  // Occupancy after this edge from the write/read pair.
  always_comb begin
    occ_nxt_s = occ_r;
    case ({wr_s, handshake_s})
      2'b10:   occ_nxt_s = occ_r + 2'd1;
      2'b01:   occ_nxt_s = occ_r - 2'd1;
      default: occ_nxt_s = occ_r;
    endcase
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable & ~empty_fifo) state_nxt_s = ST_RUN;
          else                      state_nxt_s = ST_IDLE;
        end
        ST_RUN: begin
          if (used_nxt_s == 3'd3)
            state_nxt_s = ST_BLOCKED;
          else if (~enable | (empty_fifo & (occ_r == 2'd0) & ~inflight_r))
            state_nxt_s = ST_IDLE;
          else
            state_nxt_s = ST_RUN;
        end
        ST_BLOCKED: begin
          if (handshake_s) state_nxt_s = ST_RUN;
          else             state_nxt_s = ST_BLOCKED;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Control registers: FSM, pointers, occupancy, in-flight flag, counter, status.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_r      <= ST_IDLE;
      wr_ptr_r     <= 2'd0;
      rd_ptr_r     <= 2'd0;
      occ_r        <= 2'd0;
      inflight_r   <= 1'b0;
      word_count_r <= {count_width{1'b0}};
      low_water_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      low_water_r <= almost_empty_fifo & ~empty_fifo;
      if (flush) begin
        wr_ptr_r   <= 2'd0;
        rd_ptr_r   <= 2'd0;
        occ_r      <= 2'd0;
        inflight_r <= 1'b0;
      end else begin
        occ_r      <= occ_nxt_s;
        inflight_r <= pop_s;
        if (wr_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
        if (handshake_s) begin
          rd_ptr_r     <= ptr_inc(rd_ptr_r);
          word_count_r <= word_count_r + {{(count_width-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Buffer storage: the word requested last cycle lands at the tail.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < 3; i++) buf_r[i] <= {data_width{1'b0}};
    end else if (wr_s) begin
      buf_r[wr_ptr_r] <= FIFO_data_out;
    end
  end

  assign pop        = pop_s;
  assign out_valid  = (occ_r != 2'd0);
  assign out_data   = (occ_r != 2'd0) ? buf_r[rd_ptr_r] : {data_width{1'b0}};
  assign word_count = word_count_r;
  assign state      = state_r;
  assign low_water  = low_water_r;

endmodule
